// File: rtl/fifo_reader_pkg.sv
// Shared sizing and pointer helper for the FIFO stream reader.
// Optional word counter is enabled by defining FIFO_READER_CNT_EN.
package fifo_reader_pkg;

  localparam int BUF_DEPTH = 3;
  localparam int OCC_W     = 2;
  localparam int PTR_W     = 2;

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Advance a buffer pointer, wrapping from the last entry back to zero.
  function automatic ptr_t nextPtr(input ptr_t p);
    if (p == ptr_t'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Three-entry circular skid buffer used by the FIFO stream reader.
// The head entry is always presented from registers so the stream side
// never sees the FIFO read data combinationally.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_data,
  output occ_t                  o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  ptr_t                  r_wrPtr;
  ptr_t                  r_rdPtr;
  occ_t                  r_occ;

  logic w_doPop;
  logic w_doPush;

  // Pops never underflow; a push into a full buffer is only taken when a
  // pop frees an entry in the same cycle.
  assign w_doPop  = i_pop && (r_occ != '0);
  assign w_doPush = i_push && ((r_occ != occ_t'(BUF_DEPTH)) || w_doPop);

  // Pointer and occupancy update; clear drops everything in one edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_doPop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      r_occ <= r_occ + occ_t'(w_doPush) - occ_t'(w_doPop);
    end
  end

  // Storage array; zeroed on reset so the head reads zero out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_doPush && !i_clear) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  assign o_data = r_mem[r_rdPtr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through-less FIFO (one cycle read latency) into
// a valid/ready stream, keeping at most three words buffered or in flight.
// Define FIFO_READER_CNT_EN to add the o_word_cnt transfer counter port.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_rdclk,
  input  logic                  i_rdrst,
  input  logic                  i_empty,
  output logic                  o_rden,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [15:0]           o_word_cnt
`endif
);

  logic       r_infl;
  occ_t       w_occ;
  logic [2:0] w_used;
  logic       w_rden;
  logic       w_push;
  logic       w_pop;

  // Only request a word when there is guaranteed room for it, counting the
  // word already on its way; reset gates the request immediately.
  assign w_used  = {1'b0, w_occ} + {2'b00, r_infl};
  assign w_rden  = !i_rdrst && !i_empty && !i_flush && (w_used < 3'(BUF_DEPTH));
  assign o_rden  = w_rden;

  // A word arriving while a flush is requested is dropped.
  assign w_push  = r_infl && !i_flush;
  assign o_valid = (w_occ != '0);
  assign w_pop   = o_valid && i_ready;

  // Track the read issued last cycle so its data is captured this cycle.
  always_ff @(posedge i_rdclk or posedge i_rdrst) begin
    if (i_rdrst) begin
      r_infl <= 1'b0;
    end else begin
      r_infl <= w_rden;
    end
  end

  fifo_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .i_clk   (i_rdclk),
    .i_rst   (i_rdrst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (i_flush),
    .i_wdata (i_rdata),
    .o_data  (o_data),
    .o_occ   (w_occ)
  );

`ifdef FIFO_READER_CNT_EN
  logic [15:0] r_wordCnt;

  // Count every accepted transfer, including one that coincides with a
  // flush; only reset clears the count and it wraps naturally.
  always_ff @(posedge i_rdclk or posedge i_rdrst) begin
    if (i_rdrst) begin
      r_wordCnt <= '0;
    end else if (w_pop) begin
      r_wordCnt <= r_wordCnt + 16'd1;
    end
  end

  assign o_word_cnt = r_wordCnt;
`endif

endmodule
